sdram_byte_adapter: RTL
=======================

SDRAM_BYTE_ADAPTER -- requirements
Module: sdram_byte_adapter

Interface
REQ-001 Parameter ADDR_BITS, default 24, SDRAM word-address width of the downstream sdram_bus channel.
REQ-002 clk  input  1  single clock; all logic on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req  input  1  one-cycle byte-access request pulse from the upstream cartridge logic.
REQ-005 we  input  1  1 = byte write, 0 = byte read; sampled with req.
REQ-006 address  input  ADDR_BITS+1  byte address; bit 0 selects the byte (0 = data[7:0], 1 = data[15:8]); upper bits select the word.
REQ-007 wdata  input  8  write byte; sampled with req.
REQ-008 flush  input  1  invalidates the word cache.
REQ-009 rdata  output  8  read byte; valid while busy=0 after a read completes.
REQ-010 busy  output  1  high from the cycle after an accepted req until completion.
REQ-011 mem_req, mem_we, mem_address[ADDR_BITS], mem_data_write[16]  output  drive one sdram_bus channel as master.
REQ-012 mem_data_read[16], mem_busy  input  response side of the same channel.

Function
REQ-013 The adapter SHALL accept req only in IDLE; req while busy=1 is ignored.
REQ-014 Downstream contract: mem_req is a registered one-cycle pulse; the adapter SHALL ignore mem_busy in the mem_req cycle and treat the first later cycle with mem_busy=0 as completion, with mem_data_read valid in that cycle.
REQ-015 States: IDLE, HIT, RD_WAIT, RMW_RD_WAIT, WR_WAIT.
REQ-016 The cache SHALL be a single entry: valid bit, word tag (ADDR_BITS), 16-bit data.
REQ-017 Read hit: IDLE->HIT, busy high for exactly 1 cycle, no mem_req issued.
REQ-018 Read miss: IDLE->RD_WAIT, mem_req=1 with mem_we=0 in the first RD_WAIT cycle; on completion fill the cache, set valid, and return to IDLE.
REQ-019 Write hit: merge wdata into the cached word, update the cache, IDLE->WR_WAIT, and issue mem_req with mem_we=1 and the merged word (write-through).
REQ-020 Write miss: IDLE->RMW_RD_WAIT (mem read); on completion merge, fill the cache, go to WR_WAIT, and issue the write the following cycle.
REQ-021 Busy SHALL fall in the cycle after WR_WAIT completion; the unwritten byte of the word SHALL be preserved.
REQ-022 flush SHALL clear valid at the next edge; when flush and req coincide, flush applies first, so req is a miss.
REQ-023 flush during RD_WAIT or RMW_RD_WAIT SHALL suppress the fill (valid stays 0); the data path still completes.
REQ-024 The top word address 2^ADDR_BITS-1 SHALL behave like any other word; there is no wrap.

Reset
REQ-025 With rst_n=0: state=IDLE, busy=0, mem_req=0, mem_we=0, rdata=0, mem_address=0, mem_data_write=0, valid=0.
REQ-026 Reset mid-operation SHALL abandon the access; the outstanding SDRAM operation is not tracked, and after release the adapter SHALL wait for mem_busy=0 before issuing its first mem_req.

Configuration
REQ-027 Macro SDRAM_BYTE_CACHE_EN: when defined, the cache behaves per REQ-016..023.
REQ-028 When not defined: the cache is absent, every read is a miss, every write is RMW_RD_WAIT->WR_WAIT, the HIT state is removed, and flush is ignored.

Structure
REQ-029 The state enum and cache-entry struct SHALL live in the shared sdram package alongside the sdram_bus definitions.
REQ-030 Byte merge/select SHALL be the sub-module sdram_byte_lane, which is combinational: word, byte-select, byte -> merged word and selected byte.

Verification
REQ-031 Reset, write 0x5A to byte 0x000, read 0x000 -> mem sees a read then a write of 0x??5A; the read hits with busy high for 1 cycle and rdata=0x5A.
REQ-032 Write 0xF7 to 0x001 after 0x5A at 0x000 -> SDRAM word 0 = 0xF75A; a read of 0x001 hits and returns 0xF7.
REQ-033 Read 0x002 with the cache holding word 0 -> a miss with exactly one mem read of word 1, and the cache retags to word 1.
REQ-034 flush in the same cycle as read 0x000 -> a miss with a mem read issued; the next read of 0x000 hits.
REQ-035 Write 0xA7 to byte address 2^(ADDR_BITS+1)-1 -> the top word's upper byte = 0xA7 and its lower byte is unchanged.
REQ-036 Assert rst_n=0 during RMW_RD_WAIT -> busy=0 and mem_req=0 at once; after release the next write completes correctly. Repeat all scenarios with SDRAM_BYTE_CACHE_EN undefined, expecting no HIT cycles.

Source files
------------

// File: rtl/sdram_byte_adapter_pkg.sv
// Shared SDRAM definitions: bus widths, adapter FSM states and the single-entry word cache.
// The HIT state only exists when SDRAM_BYTE_CACHE_EN is defined.
package sdram_byte_adapter_pkg;

  localparam int SDRAM_DATA_W = 16;
  // Tag storage is sized for the widest supported word address; narrower buses zero-extend.
  localparam int SDRAM_TAG_W  = 32;

  typedef enum logic [2:0] {
    IDLE,
`ifdef SDRAM_BYTE_CACHE_EN
    HIT,
`endif
    RD_WAIT,
    RMW_RD_WAIT,
    WR_WAIT
  } state_t;

  typedef struct packed {
    logic                    valid;
    logic [SDRAM_TAG_W-1:0]  tag;
    logic [SDRAM_DATA_W-1:0] data;
  } cache_entry_t;

endpackage

// File: rtl/sdram_byte_adapter_if.sv
// One sdram_bus channel: registered request pulse out, busy/read data back.
interface sdram_byte_adapter_if #(
  parameter int ADDR_BITS = 24
) ();
  logic                 mem_req;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_address;
  logic [15:0]          mem_data_write;
  logic [15:0]          mem_data_read;
  logic                 mem_busy;

  modport master (
    output mem_req, mem_we, mem_address, mem_data_write,
    input  mem_data_read, mem_busy
  );

  modport slave (
    input  mem_req, mem_we, mem_address, mem_data_write,
    output mem_data_read, mem_busy
  );
endinterface

// File: rtl/sdram_byte_adapter_lane.sv
// Combinational byte lane: merges a byte into a 16-bit word and selects one byte out of it.
module sdram_byte_lane (
  input  logic [15:0] word,
  input  logic        sel,
  input  logic [7:0]  byte_in,
  output logic [15:0] merged,
  output logic [7:0]  byte_out
);
  always_comb begin
    merged   = sel ? {byte_in, word[7:0]} : {word[15:8], byte_in};
    byte_out = sel ? word[15:8] : word[7:0];
  end
endmodule

// File: rtl/sdram_byte_adapter.sv
// Byte-wide access adapter onto a 16-bit sdram_bus channel with a write-through one-word cache.
// Optional cache enabled by defining SDRAM_BYTE_CACHE_EN; without it every access goes to SDRAM.
module sdram_byte_adapter
  import sdram_byte_adapter_pkg::*;
#(
  parameter int ADDR_BITS = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req,
  input  logic                 we,
  input  logic [ADDR_BITS:0]   address,
  input  logic [7:0]           wdata,
  input  logic                 flush,
  output logic [7:0]           rdata,
  output logic                 busy,
  sdram_byte_adapter_if.master mem
);

  state_t               state;
  logic                 pending;
  logic                 launch;
  logic                 mem_done;
  logic                 sel_q;
  logic [7:0]           wdata_q;
  logic [ADDR_BITS-1:0] req_word;

  logic [15:0]          lane_word;
  logic                 lane_sel;
  logic [7:0]           lane_byte;
  logic [15:0]          merged;
  logic [7:0]           picked;

  assign req_word = address[ADDR_BITS:1];
  // A request can only be launched once any operation left over from before reset has drained.
  assign launch   = ~mem.mem_busy;
  assign mem_done = ~pending & ~mem.mem_req & ~mem.mem_busy;

`ifdef SDRAM_BYTE_CACHE_EN
  cache_entry_t         cache;
  logic                 hit;
  logic                 kill;
  logic [ADDR_BITS-1:0] word_q;

  assign hit = cache.valid & ~flush & (cache.tag == SDRAM_TAG_W'(req_word));
`else
  logic unused_flush;
  assign unused_flush = flush;
`endif

  // In IDLE the lane works on the cached word with live inputs; otherwise on returned SDRAM data.
  always_comb begin
    lane_word = mem.mem_data_read;
    lane_sel  = sel_q;
    lane_byte = wdata_q;
`ifdef SDRAM_BYTE_CACHE_EN
    if (state == IDLE) begin
      lane_word = cache.data;
      lane_sel  = address[0];
      lane_byte = wdata;
    end
`endif
  end

  sdram_byte_lane u_lane (
    .word     (lane_word),
    .sel      (lane_sel),
    .byte_in  (lane_byte),
    .merged   (merged),
    .byte_out (picked)
  );

  always_ff @(posedge clk) begin
    if (state == IDLE && req) begin
      sel_q   <= address[0];
      wdata_q <= wdata;
`ifdef SDRAM_BYTE_CACHE_EN
      word_q  <= req_word;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      busy               <= 1'b0;
      pending            <= 1'b0;
      rdata              <= 8'h00;
      mem.mem_req        <= 1'b0;
      mem.mem_we         <= 1'b0;
      mem.mem_address    <= '0;
      mem.mem_data_write <= 16'h0000;
`ifdef SDRAM_BYTE_CACHE_EN
      kill               <= 1'b0;
`endif
    end else begin
      mem.mem_req <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            busy            <= 1'b1;
            mem.mem_address <= req_word;
`ifdef SDRAM_BYTE_CACHE_EN
            kill            <= 1'b0;
            if (hit && !we) begin
              state <= HIT;
              rdata <= picked;
            end else if (hit && we) begin
              state              <= WR_WAIT;
              mem.mem_we         <= 1'b1;
              mem.mem_data_write <= merged;
              mem.mem_req        <= launch;
              pending            <= ~launch;
            end else
`endif
            begin
              state       <= we ? RMW_RD_WAIT : RD_WAIT;
              mem.mem_we  <= 1'b0;
              mem.mem_req <= launch;
              pending     <= ~launch;
            end
          end
        end
`ifdef SDRAM_BYTE_CACHE_EN
        HIT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
`endif
        RD_WAIT, RMW_RD_WAIT, WR_WAIT: begin
`ifdef SDRAM_BYTE_CACHE_EN
          if (flush && state != WR_WAIT) kill <= 1'b1;
`endif
          if (pending) begin
            if (!mem.mem_busy) begin
              mem.mem_req <= 1'b1;
              pending     <= 1'b0;
            end
          end else if (mem_done) begin
            if (state == RD_WAIT) begin
              state <= IDLE;
              busy  <= 1'b0;
              rdata <= picked;
            end else if (state == RMW_RD_WAIT) begin
              state              <= WR_WAIT;
              mem.mem_we         <= 1'b1;
              mem.mem_data_write <= merged;
              mem.mem_req        <= 1'b1;
            end else begin
              state      <= IDLE;
              busy       <= 1'b0;
              mem.mem_we <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SDRAM_BYTE_CACHE_EN
  // Fills are dropped if a flush arrived at any point while the read was outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cache <= '0;
    end else if (state == IDLE && req && hit && we) begin
      cache.data <= merged;
    end else if ((state == RD_WAIT || state == RMW_RD_WAIT) && mem_done) begin
      cache.valid <= ~(kill | flush);
      cache.tag   <= SDRAM_TAG_W'(word_q);
      cache.data  <= (state == RD_WAIT) ? mem.mem_data_read : merged;
    end else if (flush) begin
      cache.valid <= 1'b0;
    end
  end
`endif

endmodule
